// File: rtl/a25_wishbone_pkg.sv
// Shared definitions for the Amber wishbone core-side port modules.
package a25_wishbone_pkg;

    localparam int unsigned WB_DW    = 128;
    localparam int unsigned WB_AW    = 32;
    localparam int unsigned WB_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/a25_wb_sync_fifo.sv
// Synchronous FIFO for posted write entries; pointers carry a wrap bit.
module a25_wb_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("a25_wb_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      w_one;

    assign w_one = {{PW{1'b0}}, 1'b1};

    // Pointer advance; reset discards all held entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + w_one;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + w_one;
        end
    end

    // Entry storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/a25_wishbone_post_fifo.sv
// Core-side wishbone port buffer: posts writes, drains them before issuing
// an unbuffered read, and returns read data with the ack.
module a25_wishbone_post_fifo
    import a25_wishbone_pkg::*;
#(
    parameter int unsigned DW    = WB_DW,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic                    i_write,
    input  logic [DW-1:0]           i_wdata,
    input  logic [DW/8-1:0]         i_be,
    input  logic [AW-1:0]           i_addr,
    output logic [DW-1:0]           o_rdata,
    output logic                    o_ack,
    output logic                    o_valid,
    input  logic                    i_accepted,
    output logic                    o_write,
    output logic [DW-1:0]           o_wdata,
    output logic [DW/8-1:0]         o_be,
    output logic [AW-1:0]           o_addr,
    input  logic [DW-1:0]           i_rdata,
    input  logic                    i_rdata_valid,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_full
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned EW = DW + BW + AW;

    if ((DW % 8) != 0) begin : g_dw_check
        $error("a25_wishbone_post_fifo: DW must be a multiple of 8");
    end

    rd_state_t     r_state;
    logic          w_push;
    logic          w_pop;
    logic          w_rd_ack;
    logic          w_empty;
    logic [EW-1:0] w_head;
    logic [DW-1:0] w_head_wdata;
    logic [BW-1:0] w_head_be;
    logic [AW-1:0] w_head_addr;

    // A full FIFO never takes a write, even when the head pops this cycle.
    assign w_push   = i_req & i_write & ~o_full & (r_state == IDLE) & ~i_rst;
    assign w_pop    = ~w_empty & i_accepted & ~i_rst;
    assign w_rd_ack = (r_state == RD_WAIT) & i_rdata_valid & ~i_rst;
    assign o_ack    = w_push | w_rd_ack;
    assign o_rdata  = i_rdata;

    a25_wb_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  ({i_wdata, i_be, i_addr}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (o_level),
        .o_full  (o_full),
        .o_empty (w_empty)
    );

    assign {w_head_wdata, w_head_be, w_head_addr} = w_head;

    // Read sequencing: a read is issued only once all posted writes drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:     if (i_req & ~i_write & w_empty) r_state <= RD_ISSUE;
                RD_ISSUE: if (i_accepted)                 r_state <= RD_WAIT;
                RD_WAIT:  if (i_rdata_valid)              r_state <= IDLE;
                default:                                  r_state <= IDLE;
            endcase
        end
    end

    // Bus request mux: posted writes first, otherwise the pending read.
    always_comb begin
        o_valid = 1'b0;
        o_write = 1'b0;
        o_wdata = w_head_wdata;
        o_be    = '1;
        o_addr  = i_addr;
        if (!w_empty) begin
            o_valid = ~i_rst;
            o_write = 1'b1;
            o_be    = w_head_be;
            o_addr  = w_head_addr;
        end else if (r_state == RD_ISSUE) begin
            o_valid = ~i_rst;
        end
    end

endmodule

// File: tb/tb_a25_wishbone_post_fifo.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_a25_wishbone_post_fifo;

    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          i_rst, i_req, i_write, i_accepted, i_rdata_valid;
    logic [DW-1:0] i_wdata, i_rdata;
    logic [BW-1:0] i_be;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] o_rdata, o_wdata;
    logic          o_ack, o_valid, o_write, o_full;
    logic [BW-1:0] o_be;
    logic [AW-1:0] o_addr;
    logic [LW-1:0] o_level;

    a25_wishbone_post_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_write       (i_write),
        .i_wdata       (i_wdata),
        .i_be          (i_be),
        .i_addr        (i_addr),
        .o_rdata       (o_rdata),
        .o_ack         (o_ack),
        .o_valid       (o_valid),
        .i_accepted    (i_accepted),
        .o_write       (o_write),
        .o_wdata       (o_wdata),
        .o_be          (o_be),
        .o_addr        (o_addr),
        .i_rdata       (i_rdata),
        .i_rdata_valid (i_rdata_valid),
        .o_level       (o_level),
        .o_full        (o_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of posted writes and a read-progress stage
    // (0 = no read, 1 = read waiting for bus acceptance, 2 = awaiting data).
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } ent_t;

    ent_t        mq[$];
    int          m_rd;
    int          sz;
    bit          do_push, do_pop, do_issue;
    bit          e_ack, e_valid, e_rdack;
    logic [AW-1:0] dut_pops[$];

    // Model state advance on each clock edge, from the inputs only.
    always @(posedge clk) begin
        if (i_rst) begin
            mq.delete();
            m_rd = 0;
        end else begin
            sz       = mq.size();
            do_push  = i_req && i_write && (sz < DEPTH) && (m_rd == 0);
            do_pop   = (sz > 0) && i_accepted;
            do_issue = (m_rd == 0) && i_req && !i_write && (sz == 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back('{addr: i_addr, data: i_wdata, be: i_be});
            case (m_rd)
                0: if (do_issue)      m_rd = 1;
                1: if (i_accepted)    m_rd = 2;
                2: if (i_rdata_valid) m_rd = 0;
                default: m_rd = 0;
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        sz      = mq.size();
        e_rdack = !i_rst && (m_rd == 2) && i_rdata_valid;
        e_ack   = !i_rst && ((i_req && i_write && (sz < DEPTH) && (m_rd == 0)) || e_rdack);
        e_valid = !i_rst && ((sz > 0) || (m_rd == 1));
        chk("ack",   o_ack,   e_ack);
        chk("valid", o_valid, e_valid);
        chk("level", o_level, sz);
        chk("full",  o_full,  sz == DEPTH);
        if (e_valid) begin
            if (sz > 0) begin
                chk("bus_write", o_write, 1'b1);
                chk("bus_addr",  o_addr,  mq[0].addr);
                chk("bus_be",    o_be,    mq[0].be);
                chk("bus_wdata", o_wdata, mq[0].data);
            end else begin
                chk("bus_write", o_write, 1'b0);
                chk("bus_addr",  o_addr,  i_addr);
                chk("bus_be",    o_be,    {BW{1'b1}});
            end
        end
        if (e_rdack) chk("rdata", o_rdata, i_rdata);
        if (!i_rst && o_valid && i_accepted && o_write) dut_pops.push_back(o_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [AW-1:0] a);
        i_req   = 1'b1;
        i_write = 1'b1;
        i_addr  = a;
        i_wdata = {4{a ^ 32'h5A5A_0000}};
        i_be    = a[BW-1:0] | 16'h0101;
    endtask

    task automatic set_rd(input logic [AW-1:0] a);
        i_req   = 1'b1;
        i_write = 1'b0;
        i_addr  = a;
    endtask

    // Hold a write request until acked, bounded.
    task automatic do_write(input logic [AW-1:0] a, inout logic [AW-1:0] sent[$]);
        bit done;
        done = 1'b0;
        set_wr(a);
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (o_ack) begin
                done = 1'b1;
                sent.push_back(a);
            end
            tick;
        end
        if (!done) chk("write_ack_timeout", 1'b0, 1'b1);
        i_req = 1'b0;
    endtask

    task automatic drain;
        i_req      = 1'b0;
        i_accepted = 1'b1;
        for (int k = 0; k < 12 && o_level != 0; k++) tick;
        chk("drain_level", o_level, 0);
        i_accepted = 1'b0;
    endtask

    logic [AW-1:0] sent[$];

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_write = 1'b0; i_wdata = '0; i_be = '0;
        i_addr = '0; i_accepted = 1'b0; i_rdata = '0; i_rdata_valid = 1'b0;
        m_rd = 0;

        // 1: reset, four posted writes, fifth stalls
        tick; tick;
        set_wr(32'h0F0);
        #1;
        chk("rst_ack", o_ack, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_level", o_level, 0);
        tick;
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(32'h100 + 32'(4 * i));
            #1;
            chk("t1_ack", o_ack, 1'b1);
            tick;
        end
        set_wr(32'h110);
        #1;
        chk("t1_fifth_ack", o_ack, 1'b0);
        chk("t1_level", o_level, 4);
        chk("t1_full", o_full, 1'b1);
        chk("t1_head", o_addr, 32'h100);
        tick;
        #1;
        chk("t1_fifth_ack2", o_ack, 1'b0);

        // 2: one acceptance frees a slot, stalled write lands next cycle
        i_accepted = 1'b1;
        #1;
        chk("t2_no_credit", o_ack, 1'b0);
        tick;
        i_accepted = 1'b0;
        #1;
        chk("t2_ack", o_ack, 1'b1);
        chk("t2_level", o_level, 3);
        chk("t2_head", o_addr, 32'h104);
        tick;
        i_req = 1'b0;
        #1;
        chk("t2_level_after", o_level, 4);
        drain;

        // 3: read waits for the posted write to drain
        set_wr(32'h200);
        #1;
        chk("t3_wack", o_ack, 1'b1);
        tick;
        set_rd(32'h300);
        #1;
        chk("t3_rd_wait_ack", o_ack, 1'b0);
        chk("t3_head_addr", o_addr, 32'h200);
        chk("t3_head_write", o_write, 1'b1);
        tick; tick;
        i_accepted = 1'b1;
        tick;
        #1;
        chk("t3_no_early_issue", o_valid, 1'b0);
        tick;
        chk("t3_rd_valid", o_valid, 1'b1);
        chk("t3_rd_write", o_write, 1'b0);
        chk("t3_rd_addr", o_addr, 32'h300);
        chk("t3_rd_be", o_be, {BW{1'b1}});
        tick;
        i_accepted = 1'b0;
        #1;
        chk("t3_wait_valid", o_valid, 1'b0);
        chk("t3_wait_ack", o_ack, 1'b0);
        tick;
        i_rdata = 128'hDEADBEEF;
        i_rdata_valid = 1'b1;
        #1;
        chk("t3_rd_ack", o_ack, 1'b1);
        chk("t3_rdata", o_rdata, 128'hDEADBEEF);
        tick;
        i_rdata_valid = 1'b0;
        i_req = 1'b0;

        // 4: full FIFO streaming with acceptance every cycle
        sent.delete();
        dut_pops.delete();
        for (int i = 0; i < 4; i++) do_write(32'h1000 + 32'(4 * i), sent);
        i_accepted = 1'b1;
        for (int i = 4; i < 12; i++) do_write(32'h1000 + 32'(4 * i), sent);
        drain;
        chk("t4_count", dut_pops.size(), 12);
        for (int i = 0; i < 12 && i < dut_pops.size(); i++)
            chk("t4_order", dut_pops[i], 32'h1000 + 32'(4 * i));

        // 5: reset in RD_WAIT discards the read; late data ignored
        set_rd(32'h400);
        tick;
        i_accepted = 1'b1;
        #1;
        chk("t5_issue", o_valid, 1'b1);
        tick;
        i_accepted = 1'b0;
        #1;
        chk("t5_wait", o_valid, 1'b0);
        i_rst = 1'b1;
        i_req = 1'b0;
        tick;
        i_rst = 1'b0;
        i_rdata = 128'h1234;
        i_rdata_valid = 1'b1;
        #1;
        chk("t5_late_ack", o_ack, 1'b0);
        chk("t5_valid", o_valid, 1'b0);
        chk("t5_level", o_level, 0);
        tick;
        i_rdata_valid = 1'b0;
        set_rd(32'h500);
        #1;
        chk("t5_idle_valid", o_valid, 1'b0);
        tick;
        chk("t5_reissue", o_valid, 1'b1);
        chk("t5_reissue_addr", o_addr, 32'h500);
        i_accepted = 1'b1;
        tick;
        i_accepted = 1'b0;
        i_rdata = 128'hCAFE;
        i_rdata_valid = 1'b1;
        #1;
        chk("t5_rd_ack", o_ack, 1'b1);
        tick;
        i_rdata_valid = 1'b0;
        i_req = 1'b0;

        // 6: stray rdata_valid produces no ack
        i_rdata_valid = 1'b1;
        #1;
        chk("t6_stray_ack", o_ack, 1'b0);
        chk("t6_stray_valid", o_valid, 1'b0);
        tick;
        set_wr(32'h600);
        #1;
        chk("t6_wr_ack", o_ack, 1'b1);
        tick;
        i_rdata_valid = 1'b0;
        i_req = 1'b0;
        #1;
        chk("t6_level", o_level, 1);
        drain;

        tick; tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
